// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - MIPS instruction-fetch stage: PC, req/ack fetch FSM, one-entry skid, IF/ID register
// Redirects honour one delay slot: the in-flight or already-skidded fetch completes before the target.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        inst_valid
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] sk_inst;
  logic [31:0] sk_pc4;
  logic        sk_v;
  logic        redir_pend;
  logic [31:0] redir_pc;

  logic        ack_v;
  logic        redir_acc;
  logic [31:0] target;
  logic [31:0] pc4;

  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  // An ack with no request outstanding is spurious and ignored.
  assign ack_v     = imem_ack & imem_req;
  assign redir_acc = inst_valid & ~wpcir & (pcsource != 2'b00);

  always_comb begin
    target = jpc;
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = da;
      default: target = jpc;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      sk_inst    <= 32'd0;
      sk_pc4     <= 32'd0;
      sk_v       <= 1'b0;
      redir_pend <= 1'b0;
      redir_pc   <= 32'd0;
      imem_req   <= 1'b0;
      inst       <= 32'd0;
      dpc4       <= 32'd0;
      inst_valid <= 1'b0;
    end else begin
      // Delay slot already fetched (ack now or sitting in skid): jump immediately.
      if (redir_acc && (ack_v || sk_v)) begin
        pc         <= target;
        redir_pend <= 1'b0;
      end else if (redir_acc) begin
        redir_pend <= 1'b1;
        redir_pc   <= target;
      end else if (ack_v) begin
        if (redir_pend) begin
          pc         <= redir_pc;
          redir_pend <= 1'b0;
        end else begin
          pc <= pc4;
        end
      end

      case (state)
        FETCH: begin
          if (ack_v && wpcir) begin
            sk_inst  <= imem_rdata;
            sk_pc4   <= pc4;
            sk_v     <= 1'b1;
            state    <= HOLD;
            imem_req <= 1'b0;
          end else begin
            imem_req <= 1'b1;
            if (!wpcir) begin
              if (ack_v) begin
                inst       <= imem_rdata;
                dpc4       <= pc4;
                inst_valid <= 1'b1;
              end else begin
                inst       <= 32'd0;
                inst_valid <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (!wpcir) begin
            inst       <= sk_inst;
            dpc4       <= sk_pc4;
            inst_valid <= 1'b1;
            sk_v       <= 1'b0;
            state      <= FETCH;
            imem_req   <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage for the five-stage MIPS pipeline. It owns the PC and the IF/ID pipeline register, and issues word fetches to instruction memory over a req/ack handshake. It feeds decode with `inst`/`dpc4` and takes back the decode stage's stall (`wpcir`) and next-PC select (`pcsource`, with its three targets). Branches and jumps have one architectural delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `wpcir`  in  1  decode stall; 1 = hold PC request flow into IF/ID and hold IF/ID.
- `pcsource`  in  2  from decode: 00 = sequential, 01 = `bpc`, 10 = `da` (jr/jalr), 11 = `jpc`.
- `bpc`, `da`, `jpc`  in  32 each  redirect targets, valid in the same cycle as `pcsource`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address, registered.
- `imem_ack`  in  1  read data valid; at most one outstanding request.
- `imem_rdata`  in  32  instruction word, sampled when `imem_ack`=1.
- `inst`  out  32  IF/ID instruction.
- `dpc4`  out  32  IF/ID fetch address + 4.
- `inst_valid`  out  1  IF/ID holds a real instruction; 0 = bubble.

## Operation
- Registers:
  - `pc`: next fetch address, driven on `imem_addr`.
  - One-entry skid buffer: `sk_inst`, `sk_pc4`, `sk_v`.
  - `redir_pend`, `redir_pc`.
  - IF/ID: `inst`, `dpc4`, `inst_valid`.
  - FSM state.
- FSM states:
  - FETCH:
    - `imem_req`=1.
    - `imem_addr`=`pc`, held stable until `imem_ack`.
  - HOLD:
    - `imem_req`=0.
    - `sk_v`=1.
- FETCH, ack with `wpcir`=0: word and `pc+4` load into IF/ID with `inst_valid`=1. Stay in FETCH.
- FETCH, ack with `wpcir`=1: word goes to the skid buffer. Go to HOLD.
- FETCH, no ack with `wpcir`=0: IF/ID loads a bubble (`inst`=0, `dpc4` unchanged, `inst_valid`=0).
- HOLD with `wpcir`=0: the skid buffer moves into IF/ID, `sk_v` clears, and the FSM returns to FETCH.
- Any state with `wpcir`=1: IF/ID holds.
- PC advance on every ack:
  - Default is `pc <= pc+4`.
  - If `redir_pend` is set, `pc <= redir_pc` and `redir_pend` clears.
- Redirect is accepted when all of these hold:
  - `inst_valid`=1
  - `wpcir`=0
  - `pcsource`!=00
- Selected target: 01 → `bpc`, 10 → `da`, 11 → `jpc`.
- Delay-slot rule for an accepted redirect:
  - `imem_ack`=1 this cycle (the ack is the delay slot): `pc <= target`.
  - Else if `sk_v`=1 (delay slot already fetched): `pc <= target`.
  - Else: `redir_pend <= 1` and `redir_pc <= target`. The delay-slot fetch completes first.
- Redirect targets and all PC values are used as given. There is no alignment check. All PC arithmetic is modulo 2^32.
- `imem_ack` while `imem_req`=0 is ignored.

## Timing
- Reset values:
  - `pc`=`RESET_PC`
  - `imem_req`=0
  - `inst`=0, `dpc4`=0, `inst_valid`=0
  - `sk_v`=0, `redir_pend`=0
  - FSM in FETCH
- `imem_req` rises on the first clock edge after `resetn` deasserts.
- Latency: an ack in cycle T with `wpcir`=0 shows `inst` in cycle T+1.
- Throughput with single-cycle memory: 1 instruction per cycle.
- `imem_addr` updates on the edge that samples the ack.
- Reset asserted mid-operation:
  - All state clears immediately, with no clock needed.
  - Any pending redirect and the outstanding request are discarded.
  - The memory is reset with the same `resetn`.

## Test plan
- Sequential fetch:
  - Stimulus: reset, `RESET_PC`=0, ack every cycle, `wpcir`=0.
  - Required: `imem_addr` goes 0,4,8,C on consecutive cycles. `inst` follows one cycle later with `dpc4` = 4,8,C,10. No bubbles.
- Stall with skid:
  - Stimulus: `wpcir`=1 for 3 cycles while the word for 0x8 acks.
  - Required: FSM goes to HOLD and `imem_req`=0 for those cycles. IF/ID keeps the 0x4 word. On release, the 0x8 word enters IF/ID and the next request is 0xC.
- Branch, same-cycle delay slot:
  - Stimulus: instruction at 0x10 in ID with `pcsource`=01, `bpc`=0x40, ack for 0x14 in that same cycle.
  - Required: next `imem_addr`=0x40. The 0x14 word reaches IF/ID.
- Branch with slow memory:
  - Stimulus: ack 3 cycles after request, `jpc`=0x100 accepted while 0x14 is still in flight.
  - Required: `redir_pend`=1 and the 0x14 request is held. After the 0x14 ack, `imem_addr`=0x100. Bubbles (`inst_valid`=0) appear meanwhile.
- jr during a skid hold:
  - Stimulus: skid holds 0x14, `pcsource`=10, `da`=0x2000.
  - Required: `pc` becomes 0x2000 without waiting for another ack.
- Reset mid-fetch:
  - Stimulus: drop `resetn` while a request is outstanding and `redir_pend`=1.
  - Required: `imem_req`, `inst_valid` and `redir_pend` go to 0 asynchronously. The first fetch after release is at `RESET_PC`.
